// File: rtl/mem_read_seq_m1_if.sv
// mem_read_seq_m1_if
//   Bundles the control and index signals of the matrix-1 read-address
//   sequencer.
//   master : the sequencer (takes start/hold, drives indices and status)
//   slave  : controller / skew stage side
//   start  - one-cycle pass request
//   hold   - stall while issuing
//   row    - row index, 0..M-1
//   column - column-group index, 0..M/N-1
//   rd_en  - index valid this cycle
//   last   - final index of the pass
//   busy   - pass in progress (any non-idle state)
//   done   - one-cycle pulse once all reads plus the skew drain are complete
interface mem_read_seq_m1_if #(
    parameter int N = 3,
    parameter int M = 6
);
    localparam int RW = $clog2(M);
    localparam int CW = $clog2(M / N);

    logic          start;
    logic          hold;
    logic [RW-1:0] row;
    logic [CW-1:0] column;
    logic          rd_en;
    logic          last;
    logic          busy;
    logic          done;

    modport master (
        input  start, hold,
        output row, column, rd_en, last, busy, done
    );

    modport slave (
        output start, hold,
        input  row, column, rd_en, last, busy, done
    );
endinterface

// File: rtl/mem_read_seq_m1.sv
// mem_read_seq_m1
//   Read-address sequencer for the matrix-1 operand store. A start pulse
//   walks every (row, column-group) index column-major, with row as the
//   inner loop, for M*M/N issue cycles. The skew stage turns each index into
//   a per-bank address (column*M + row). After the final index the sequencer
//   waits N+1 cycles so the skew pipeline has launched every bank read, then
//   pulses done.
// Ports
//   clk  - rising-edge clock
//   rst  - synchronous reset, active high; aborts a pass without a done pulse
//   bus  - mem_read_seq_m1_if.master (start, hold in; row, column, rd_en,
//          last, busy, done out)
module mem_read_seq_m1 #(
    parameter int N = 3,
    parameter int M = 6
) (
    input  logic               clk,
    input  logic               rst,
    mem_read_seq_m1_if.master  bus
);
    localparam int COLS = M / N;
    localparam int RW   = $clog2(M);
    localparam int CW   = $clog2(COLS);
    localparam int DW   = $clog2(N + 1);

    localparam logic [RW-1:0] ROW_LAST   = RW'(M - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [DW-1:0] drain_cnt;

    logic rd_en;
    logic row_last;
    logic col_last;

    // Hold only gates issue; the counters simply do not advance, so the
    // index order is untouched by any stall pattern.
    assign rd_en    = (state == READ) & ~bus.hold;
    assign row_last = (row_q == ROW_LAST);
    assign col_last = (col_q == COL_LAST);

    assign bus.row    = row_q;
    assign bus.column = col_q;
    assign bus.rd_en  = rd_en;
    assign bus.last   = rd_en & row_last & col_last;
    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                // Counters are already at (0,0) here: both reset and the
                // final issue leave them there.
                IDLE: begin
                    if (bus.start)
                        state <= READ;
                end

                READ: begin
                    if (rd_en) begin
                        if (row_last) begin
                            row_q <= '0;
                            if (col_last) begin
                                col_q     <= '0;
                                drain_cnt <= DRAIN_LOAD;
                                state     <= DRAIN;
                            end else begin
                                col_q <= col_q + CW'(1);
                            end
                        end else begin
                            row_q <= row_q + RW'(1);
                        end
                    end
                end

                // Loaded with N on entry and leaves at zero: N+1 cycles,
                // matching the skew stage depth. Cannot be stalled.
                DRAIN: begin
                    if (drain_cnt == '0)
                        state <= DONE;
                    else
                        drain_cnt <= drain_cnt - DW'(1);
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_read_seq_m1.sv
// tb_mem_read_seq_m1
//   Directed bench for mem_read_seq_m1. Two instances: default (N=3, M=6) and
//   (N=2, M=8). Both share start/hold/rst; each test looks only at the
//   instance it targets. Cycle c of a trace is the interval after the c-th
//   clock edge of that trace; inputs change 1ns after the edge and outputs
//   are sampled on the falling edge.
module tb_mem_read_seq_m1;
    logic clk;
    logic rst;
    logic start;
    logic hold;

    mem_read_seq_m1_if #(.N(3), .M(6)) b1 ();
    mem_read_seq_m1_if #(.N(2), .M(8)) b2 ();

    assign b1.start = start;
    assign b1.hold  = hold;
    assign b2.start = start;
    assign b2.hold  = hold;

    mem_read_seq_m1 #(.N(3), .M(6)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));
    mem_read_seq_m1 #(.N(2), .M(8)) dut2 (.clk(clk), .rst(rst), .bus(b2.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // trace storage, dut1 (t_*) and dut2 (u_*)
    logic        t_rd[64], t_last[64], t_busy[64], t_done[64];
    logic [31:0] t_row[64], t_col[64];
    logic        u_rd[64], u_last[64], u_done[64];
    logic [31:0] u_row[64], u_col[64];

    int exp_row[12] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
    int exp_col[12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Drive start/hold/rst per cycle from masks and record both DUTs.
    task automatic run_trace(input int ncyc, input logic [63:0] sm,
                             input logic [63:0] hm, input int rc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            start = sm[c];
            hold  = hm[c];
            rst   = (c == rc);
            @(negedge clk);
            t_rd[c]   = b1.rd_en;  t_last[c] = b1.last;
            t_busy[c] = b1.busy;   t_done[c] = b1.done;
            t_row[c]  = 32'(b1.row); t_col[c] = 32'(b1.column);
            u_rd[c]   = b2.rd_en;  u_last[c] = b2.last;
            u_done[c] = b2.done;
            u_row[c]  = 32'(b2.row); u_col[c] = 32'(b2.column);
        end
        @(posedge clk); #1;
        start = 1'b0; hold = 1'b0; rst = 1'b0;
    endtask

    // 0 rd1, 1 last1, 2 done1, 3 busy1, 4 rd2, 5 last2, 6 done2
    function automatic logic sig(input int w, input int c);
        case (w)
            0: return t_rd[c];
            1: return t_last[c];
            2: return t_done[c];
            3: return t_busy[c];
            4: return u_rd[c];
            5: return u_last[c];
            6: return u_done[c];
            default: return 1'b0;
        endcase
    endfunction

    function automatic int first_of(input int w, input int lo, input int hi);
        for (int c = lo; c <= hi; c++)
            if (sig(w, c) === 1'b1) return c;
        return -1;
    endfunction

    function automatic int count_of(input int w, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++)
            if (sig(w, c) === 1'b1) n++;
        return n;
    endfunction

    // Issued indices of dut1 in cycles lo..hi must be the default 12-entry walk.
    task automatic chk_walk(input string tag, input int lo, input int hi);
        int k = 0;
        for (int c = lo; c <= hi; c++) begin
            if (t_rd[c] === 1'b1) begin
                if (k < 12) begin
                    chk($sformatf("%s row#%0d", tag, k), t_row[c], 32'(exp_row[k]));
                    chk($sformatf("%s col#%0d", tag, k), t_col[c], 32'(exp_col[k]));
                end
                k++;
            end
        end
        chk({tag, " issues"}, 32'(k), 32'd12);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] sm;
        logic [63:0] hm;
        rst = 1'b1; start = 1'b0; hold = 1'b0;

        // 1: reset then idle
        do_reset();
        run_trace(5, 64'd0, 64'd0, -1);
        chk("rst rd_en",  32'(t_rd[4]),   32'd0);
        chk("rst last",   32'(t_last[4]), 32'd0);
        chk("rst busy",   32'(t_busy[4]), 32'd0);
        chk("rst done",   32'(t_done[4]), 32'd0);
        chk("rst row",    t_row[4], 32'd0);
        chk("rst column", t_col[4], 32'd0);

        // 2: plain pass
        do_reset();
        sm = '0; sm[0] = 1'b1;
        run_trace(20, sm, 64'd0, -1);
        chk("p2 first rd", 32'(first_of(0, 0, 19)), 32'd1);
        chk("p2 rd count", 32'(count_of(0, 0, 19)), 32'd12);
        chk_walk("p2", 0, 19);
        chk("p2 last cyc", 32'(first_of(1, 0, 19)), 32'd12);
        chk("p2 last cnt", 32'(count_of(1, 0, 19)), 32'd1);
        chk("p2 done cyc", 32'(first_of(2, 0, 19)), 32'd17);
        chk("p2 done cnt", 32'(count_of(2, 0, 19)), 32'd1);
        for (int c = 0; c < 20; c++)
            chk($sformatf("p2 busy c%0d", c), 32'(t_busy[c]), 32'((c >= 1 && c <= 17) ? 1 : 0));

        // 3: hold in cycles 4-6 of READ
        do_reset();
        sm = '0; sm[0] = 1'b1;
        hm = '0; hm[4] = 1'b1; hm[5] = 1'b1; hm[6] = 1'b1;
        run_trace(23, sm, hm, -1);
        chk_walk("p3", 0, 22);
        chk("p3 rd in hold", 32'(count_of(0, 4, 6)), 32'd0);
        chk("p3 last cyc", 32'(first_of(1, 0, 22)), 32'd15);
        chk("p3 done cyc", 32'(first_of(2, 0, 22)), 32'd20);
        chk("p3 done cnt", 32'(count_of(2, 0, 22)), 32'd1);

        // 4: starts during READ, DRAIN, DONE ignored; start at 19 restarts
        do_reset();
        sm = '0; sm[0] = 1'b1; sm[3] = 1'b1; sm[14] = 1'b1; sm[17] = 1'b1; sm[19] = 1'b1;
        run_trace(22, sm, 64'd0, -1);
        chk("p4 row c4",   t_row[4], 32'd3);
        chk("p4 rd count", 32'(count_of(0, 0, 18)), 32'd12);
        chk("p4 done cyc", 32'(first_of(2, 0, 21)), 32'd17);
        chk("p4 done cnt", 32'(count_of(2, 0, 21)), 32'd1);
        chk("p4 busy c18", 32'(t_busy[18]), 32'd0);
        chk("p4 busy c19", 32'(t_busy[19]), 32'd0);
        chk("p4 rd c20",   32'(t_rd[20]), 32'd1);
        chk("p4 row c20",  t_row[20], 32'd0);
        chk("p4 col c20",  t_col[20], 32'd0);

        // 5: reset in cycle 7 aborts; new start at 10 replays full timing
        do_reset();
        sm = '0; sm[0] = 1'b1; sm[10] = 1'b1;
        run_trace(30, sm, 64'd0, 7);
        chk("p5 rd c7",    32'(t_rd[7]),   32'd1);
        chk("p5 rd c8",    32'(t_rd[8]),   32'd0);
        chk("p5 busy c8",  32'(t_busy[8]), 32'd0);
        chk("p5 last c8",  32'(t_last[8]), 32'd0);
        chk("p5 done c8",  32'(t_done[8]), 32'd0);
        chk("p5 row c8",   t_row[8], 32'd0);
        chk("p5 col c8",   t_col[8], 32'd0);
        chk("p5 first rd", 32'(first_of(0, 8, 29)), 32'd11);
        chk_walk("p5", 8, 29);
        chk("p5 last cyc", 32'(first_of(1, 8, 29)), 32'd22);
        chk("p5 done cyc", 32'(first_of(2, 0, 29)), 32'd27);
        chk("p5 done cnt", 32'(count_of(2, 0, 29)), 32'd1);

        // 6: start with hold in IDLE; hold also through DRAIN/DONE
        do_reset();
        sm = '0; sm[0] = 1'b1;
        hm = '0; hm[0] = 1'b1; hm[1] = 1'b1; hm[2] = 1'b1;
        for (int c = 15; c <= 19; c++) hm[c] = 1'b1;
        run_trace(22, sm, hm, -1);
        chk("p6 busy c1",  32'(t_busy[1]), 32'd1);
        chk("p6 first rd", 32'(first_of(0, 0, 21)), 32'd3);
        chk_walk("p6", 0, 21);
        chk("p6 last cyc", 32'(first_of(1, 0, 21)), 32'd14);
        chk("p6 done cyc", 32'(first_of(2, 0, 21)), 32'd19);

        // 7: N=2, M=8 instance
        do_reset();
        sm = '0; sm[0] = 1'b1;
        run_trace(40, sm, 64'd0, -1);
        chk("n2 first rd", 32'(first_of(4, 0, 39)), 32'd1);
        chk("n2 rd count", 32'(count_of(4, 0, 39)), 32'd32);
        chk("n2 row c9",   u_row[9], 32'd0);
        chk("n2 col c9",   u_col[9], 32'd1);
        chk("n2 last cyc", 32'(first_of(5, 0, 39)), 32'd32);
        chk("n2 row c32",  u_row[32], 32'd7);
        chk("n2 col c32",  u_col[32], 32'd3);
        chk("n2 done cyc", 32'(first_of(6, 0, 39)), 32'd36);
        chk("n2 done-rd",  32'(first_of(6, 0, 39) - first_of(4, 0, 39)), 32'd35);
        chk("n2 done cnt", 32'(count_of(6, 0, 39)), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
